alu_datapath: RTL and testbench
===============================

ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, the operand/result byte width; all numbers below assume WIDTH=8.
REQ-002 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-low reset.
REQ-004 Port x, input, 8: operand 1 (addend/minuend, multiplier, dividend); sampled only on an init control bit.
REQ-005 Port y, input, 8: operand 2 (addend/subtrahend, multiplicand, divisor); sampled only on an init control bit.
REQ-006 Port c, input, 13: control word from the ALU sequencer; bit meanings per REQ-012..REQ-022.
REQ-007 Port q_0, output, 1: Q[0], combinational from register.
REQ-008 Port q_min1, output, 1: Booth bit Qm1, combinational from register.
REQ-009 Port sign, output, 1: A[9], the accumulator sign, combinational from register.
REQ-010 Port cnt7, output, 1: high iff the 3-bit iteration counter equals 7.
REQ-011 Ports outbus (8), out_valid (1), ovf (1), div_zero (1), all outputs, all registered.

Function
REQ-012 Internal state SHALL be: A (10 bits, signed), Q (8), M (10), Qm1 (1), cnt (3), op (2: ADDSUB, MUL, DIV).
REQ-013 c[0]: A <= sext(x), M <= sext(y), Q <= 0, Qm1 <= 0, cnt <= 0, op <= ADDSUB, ovf <= 0.
REQ-014 c[1]: A <= 0, Q <= x, M <= sext(y), Qm1 <= 0, cnt <= 0, op <= MUL.
REQ-015 c[2]: A <= 0, Q <= x, M <= zext(y), Qm1 <= 0, cnt <= 0, op <= DIV, div_zero <= (y == 0).
REQ-016 Init priority when several init bits are set in one cycle SHALL be c[0] > c[1] > c[2]; other bits are ignored in that cycle.
REQ-017 c[3]: if op==DIV, {A,Q} <= {A,Q} << 1 (Q[0] <= 0); otherwise no change.
REQ-018 c[4]: A <= A + M when c[5]=0, A <= A - M when c[5]=1, 10-bit two's-complement wrap; c[5] without c[4] has no effect; if op==ADDSUB, ovf <= (A_new[8] != A_new[7]).
REQ-019 c[6]: Q[0] <= ~A[9].
REQ-020 c[7]: arithmetic right shift of {A,Q,Qm1} by 1 (A[9] replicated).
REQ-021 c[8] and c[9]: cnt <= cnt + 1, wrapping 7 -> 0; c[10]: A <= A + M (division remainder correction).
REQ-022 c[11]: outbus <= A[7:0]; c[12]: outbus <= Q; either one SHALL make out_valid high for exactly the next cycle; otherwise outbus holds and out_valid is 0.
REQ-023 Status outputs SHALL reflect register contents before the current edge, so the sequencer samples cnt7 before the c[8]/c[9] increment; 8 loop passes therefore end with cnt7=1 on the 8th check.
REQ-024 Register updates from different bits in one cycle SHALL apply in order c[3], c[4], c[6], c[7], c[10]; c[8]/c[9] act on cnt only.
REQ-025 Results: ADDSUB gives the sum/difference on the c[11] byte; MUL gives the signed 16-bit Booth product as c[11]=high byte, c[12]=low byte; DIV gives the unsigned remainder on c[11] and the quotient on c[12].
REQ-026 Division by zero SHALL raise div_zero; the quotient and remainder are then don't-care but the block SHALL NOT hang or alter other flags.
REQ-027 A c word of all zeros SHALL hold all state.

Reset
REQ-028 While rst=0, the block SHALL clear A, Q, M, Qm1, cnt, outbus, out_valid, ovf and div_zero, and set op=ADDSUB, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL abort immediately; after release the block SHALL respond only to a fresh init bit.

Verification
REQ-030 Add: x=0x25, y=0x17; c[0], c[3], c[4], c[11] -> outbus=0x3C, out_valid pulses once, ovf=0.
REQ-031 Subtract overflow: x=0x80, y=0x01; c[0], c[4]+c[5], c[11] -> outbus=0x7F, ovf=1.
REQ-032 Booth multiply: x=0xFD, y=0x05; c[1], then 8 passes of (c[4] with c[5] per q_0/q_min1 = 10 -> sub, 01 -> add, else skip), c[7], c[9]; then c[11], c[12] -> 0xFF then 0xF1; cnt7=1 on the 8th check.
REQ-033 Non-restoring divide: x=100, y=7; c[2], then 8 passes of (c[3], c[4] with c[5]=~sign, c[6], c[8]); then c[10] if sign; then c[11], c[12] -> remainder 0x02, quotient 0x0E.
REQ-034 Reset mid-multiply (after 3 passes): rst low for 1 cycle -> all outputs 0, cnt7=0; a following ADD run (REQ-030) gives 0x3C.
REQ-035 Divide by zero: y=0x00 with c[2] -> div_zero=1 the next cycle; a later c[0] clears it... div_zero SHALL be cleared by c[0] and c[1] as well as reloaded by c[2].

Source files
------------

// File: rtl/alu_datapath.sv
// ---------------------------------------------------------------------------
// alu_datapath
//   Register datapath for a micro-sequenced ALU. An external sequencer drives
//   one control word per clock. The word selects an init operation (load
//   operands for add/sub, Booth multiply or non-restoring divide) and the
//   micro-steps that move the accumulator/quotient registers.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   x, y       operands, sampled only on an init bit (c[0], c[1], c[2])
//   c[12:0]    control word from the sequencer
//   q_0        Q[0]                    (status, from register)
//   q_min1     Booth bit Qm1           (status, from register)
//   sign       accumulator sign A[MSB] (status, from register)
//   cnt7       iteration counter at its terminal value
//   outbus     registered result byte (A low byte on c[11], Q on c[12])
//   out_valid  one-cycle pulse after an outbus load
//   ovf        signed overflow of the last add/sub in ADDSUB mode
//   div_zero   divisor was zero at the last divide init
//
// The iteration counter is log2(WIDTH) bits wide; WIDTH is expected to be a
// power of two so that the terminal count lines up with WIDTH loop passes.
// ---------------------------------------------------------------------------
module alu_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [12:0]      c,
    output logic             q_0,
    output logic             q_min1,
    output logic             sign,
    output logic             cnt7,
    output logic [WIDTH-1:0] outbus,
    output logic             out_valid,
    output logic             ovf,
    output logic             div_zero
);

    localparam int AW = WIDTH + 2;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        OP_ADDSUB = 2'd0,
        OP_MUL    = 2'd1,
        OP_DIV    = 2'd2
    } op_e;

    logic [AW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AW-1:0]    m_q, m_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] outbus_q, outbus_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic             div_zero_q, div_zero_d;

    logic [AW-1:0] x_sext;
    logic [AW-1:0] y_sext;
    logic [AW-1:0] y_zext;

    assign x_sext = {{2{x[WIDTH-1]}}, x};
    assign y_sext = {{2{y[WIDTH-1]}}, y};
    assign y_zext = {2'b00, y};

    // Micro-steps inside one word are applied as a chain on the *_d copies:
    // shift, add/sub, quotient bit, right shift, correction. Each later step
    // therefore sees the result of the earlier ones, which lets the sequencer
    // issue a whole divide or Booth pass in a single cycle.
    always_comb begin
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        qm1_d       = qm1_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        outbus_d    = outbus_q;
        out_valid_d = 1'b0;
        ovf_d       = ovf_q;
        div_zero_d  = div_zero_q;

        if (c[0]) begin
            a_d        = x_sext;
            m_d        = y_sext;
            q_d        = '0;
            qm1_d      = 1'b0;
            cnt_d      = '0;
            op_d       = OP_ADDSUB;
            ovf_d      = 1'b0;
            div_zero_d = 1'b0;
        end else if (c[1]) begin
            a_d        = '0;
            q_d        = x;
            m_d        = y_sext;
            qm1_d      = 1'b0;
            cnt_d      = '0;
            op_d       = OP_MUL;
            div_zero_d = 1'b0;
        end else if (c[2]) begin
            a_d        = '0;
            q_d        = x;
            m_d        = y_zext;
            qm1_d      = 1'b0;
            cnt_d      = '0;
            op_d       = OP_DIV;
            div_zero_d = (y == '0);
        end else begin
            if (c[3] && (op_q == OP_DIV)) begin
                {a_d, q_d} = {a_d[AW-2:0], q_d, 1'b0};
            end
            if (c[4]) begin
                a_d = c[5] ? (a_d - m_q) : (a_d + m_q);
                // Overflow of the WIDTH-bit signed result: the guard bit
                // above the byte disagrees with the byte's own sign bit.
                if (op_q == OP_ADDSUB) begin
                    ovf_d = (a_d[WIDTH] != a_d[WIDTH-1]);
                end
            end
            if (c[6]) begin
                q_d[0] = ~a_d[AW-1];
            end
            if (c[7]) begin
                {a_d, q_d, qm1_d} = {a_d[AW-1], a_d, q_d};
            end
            if (c[8] || c[9]) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (c[10]) begin
                a_d = a_d + m_q;
            end
            // Output loads take the register contents present before this
            // edge; c[12] wins if both are set.
            if (c[11]) begin
                outbus_d    = a_q[WIDTH-1:0];
                out_valid_d = 1'b1;
            end
            if (c[12]) begin
                outbus_d    = q_q;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            op_q        <= OP_ADDSUB;
            outbus_q    <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            qm1_q       <= qm1_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            outbus_q    <= outbus_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign q_0       = q_q[0];
    assign q_min1    = qm1_q;
    assign sign      = a_q[AW-1];
    assign cnt7      = &cnt_q;
    assign outbus    = outbus_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_datapath.sv
// ---------------------------------------------------------------------------
// tb_alu_datapath
//   Drives alu_datapath as its sequencer would and compares the results with
//   plain integer arithmetic (sum, difference, signed product, unsigned
//   quotient/remainder).
// ---------------------------------------------------------------------------
module tb_alu_datapath;

    logic        clk;
    logic        rst;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [12:0] c;
    logic        q_0;
    logic        q_min1;
    logic        sign;
    logic        cnt7;
    logic [7:0]  outbus;
    logic        out_valid;
    logic        ovf;
    logic        div_zero;

    int n_checks = 0;
    int n_errors = 0;

    alu_datapath #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .c         (c),
        .q_0       (q_0),
        .q_min1    (q_min1),
        .sign      (sign),
        .cnt7      (cnt7),
        .outbus    (outbus),
        .out_valid (out_valid),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one control word for one clock; outputs are stable on return.
    task automatic step(input logic [12:0] cw);
        c = cw;
        @(posedge clk);
        #1;
        c = '0;
    endtask

    function automatic int sval(input logic [7:0] v);
        logic signed [7:0] s;
        s = v;
        return int'(s);
    endfunction

    task automatic run_addsub(input logic [7:0] xv, input logic [7:0] yv, input bit sub, input string tag);
        int r;
        r = sub ? (sval(xv) - sval(yv)) : (sval(xv) + sval(yv));
        x = xv;
        y = yv;
        step(13'h0001);
        step(sub ? 13'h0030 : 13'h0010);
        step(13'h0800);
        check_val({tag, "_out"}, outbus, r & 8'hFF);
        check_val({tag, "_vld"}, out_valid, 1);
        check_val({tag, "_ovf"}, ovf, (r > 127 || r < -128) ? 1 : 0);
        step(13'h0000);
        check_val({tag, "_vld_off"}, out_valid, 0);
    endtask

    // Booth passes; the sequencer decides add/sub from the status bits.
    task automatic mul_passes(input int n, input string tag);
        logic [12:0] cw;
        for (int p = 1; p <= n; p++) begin
            cw = 13'h0280;
            if ({q_0, q_min1} == 2'b10)      cw = cw | 13'h0030;
            else if ({q_0, q_min1} == 2'b01) cw = cw | 13'h0010;
            if (p == 1 || p >= 7) check_val($sformatf("%s_cnt7_p%0d", tag, p), cnt7, (p == 8) ? 1 : 0);
            step(cw);
        end
    endtask

    task automatic run_mul(input logic [7:0] xv, input logic [7:0] yv, input string tag);
        int prod;
        prod = sval(xv) * sval(yv);
        x = xv;
        y = yv;
        step(13'h0002);
        mul_passes(8, tag);
        step(13'h0800);
        check_val({tag, "_hi"}, outbus, (prod >> 8) & 8'hFF);
        step(13'h1000);
        check_val({tag, "_lo"}, outbus, prod & 8'hFF);
    endtask

    task automatic run_div(input logic [7:0] xv, input logic [7:0] yv, input string tag);
        logic [12:0] cw;
        x = xv;
        y = yv;
        step(13'h0004);
        check_val({tag, "_dz"}, div_zero, (yv == 0) ? 1 : 0);
        for (int p = 1; p <= 8; p++) begin
            cw = 13'h0158 | (sign ? 13'h0000 : 13'h0020);
            if (p == 8) check_val({tag, "_cnt7"}, cnt7, 1);
            step(cw);
        end
        if (sign) step(13'h0400);
        step(13'h0800);
        if (yv != 0) check_val({tag, "_rem"}, outbus, int'(xv) % int'(yv));
        step(13'h1000);
        if (yv != 0) check_val({tag, "_quo"}, outbus, int'(xv) / int'(yv));
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_out"}, outbus, 0);
        check_val({tag, "_vld"}, out_valid, 0);
        check_val({tag, "_ovf"}, ovf, 0);
        check_val({tag, "_dz"}, div_zero, 0);
        check_val({tag, "_cnt7"}, cnt7, 0);
        check_val({tag, "_stat"}, {sign, q_0, q_min1}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx, ry;
        rst = 1'b0;
        x   = '0;
        y   = '0;
        c   = '0;
        #12;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_addsub(8'h25, 8'h17, 1'b0, "add");
        run_addsub(8'h80, 8'h01, 1'b1, "sub_ovf");
        run_addsub(8'h7F, 8'h01, 1'b0, "add_ovf");
        run_mul(8'hFD, 8'h05, "mul");
        run_mul(8'h80, 8'h80, "mul_min");
        run_div(8'd100, 8'd7, "div");
        run_div(8'd255, 8'd1, "div_one");

        // All-zero words hold state
        repeat (3) step(13'h0000);
        check_val("hold_vld", out_valid, 0);
        check_val("hold_out", outbus, 8'd255);
        step(13'h1000);
        check_val("hold_quo", outbus, 8'd255);

        // Several init bits: c[0] wins, other bits ignored that cycle
        x = 8'h10;
        y = 8'h00;
        step(13'h0004);
        check_val("dz_set", div_zero, 1);
        x = 8'h11;
        y = 8'h22;
        step(13'h0817);
        check_val("prio_vld", out_valid, 0);
        check_val("prio_dz", div_zero, 0);
        step(13'h0010);
        step(13'h0800);
        check_val("prio_out", outbus, 8'h33);

        // Divide by zero: flag, no effect on ovf, cleared by c[1] and c[0]
        run_addsub(8'h80, 8'h01, 1'b1, "pre_dz");
        run_div(8'd9, 8'd0, "dz");
        check_val("dz_ovf_kept", ovf, 1);
        check_val("dz_held", div_zero, 1);
        step(13'h0002);
        check_val("dz_clr_mul", div_zero, 0);
        step(13'h0004);
        check_val("dz_reload", div_zero, 1);
        step(13'h0001);
        check_val("dz_clr_add", div_zero, 0);

        // Reset mid-multiply
        run_addsub(8'h80, 8'h01, 1'b1, "pre_rst");
        x = 8'hFD;
        y = 8'h05;
        step(13'h0002);
        mul_passes(3, "rst_mul");
        rst = 1'b0;
        #2;
        check_cleared("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(13'h0800);
        check_val("post_rst_a", outbus, 0);
        run_addsub(8'h25, 8'h17, 1'b0, "post_rst_add");

        // Randomized cases
        for (int i = 0; i < 12; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            run_addsub(rx, ry, 1'($urandom_range(0, 1)), $sformatf("rnd_as%0d", i));
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            run_mul(rx, ry, $sformatf("rnd_mul%0d", i));
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(1, 255));
            run_div(rx, ry, $sformatf("rnd_div%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
